// File: rtl/ysyx_22040759_ifu_ifid.sv
// Fetch unit + IF/ID register: single-outstanding imem fetch, one-entry skid buffer, stall/flush handling.
// Optional perf counters enabled by `define YSYX_22040759_IFU_PERF_EN.
`default_nettype none

module ysyx_22040759_ifu_ifid #(
  parameter int              XLEN     = 64,
  parameter int              IW       = 32,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [IW-1:0]   imem_rdata_i,
  output logic            id_valid_o,
  output logic [XLEN-1:0] id_pc_o,
  output logic [IW-1:0]   id_inst_o
`ifdef YSYX_22040759_IFU_PERF_EN
  ,
  output logic [63:0]     perf_stall_cnt_o,
  output logic [63:0]     perf_drop_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [IW-1:0]   skid_inst_q, skid_inst_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [IW-1:0]   id_inst_q, id_inst_d;

  logic w_rsp;
  logic w_rsp_live;

  assign w_rsp      = (state_q == S_WAIT) && imem_rvalid_i;
  assign w_rsp_live = w_rsp && !drop_q && !flush_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    id_valid_d   = id_valid_q;
    id_pc_d      = id_pc_q;
    id_inst_d    = id_inst_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT;
          if (flush_i) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (w_rsp) begin
          drop_d  = 1'b0;
          state_d = (w_rsp_live && stall_i) ? S_HOLD : S_REQ;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush_i || !stall_i) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush_i) pc_d = redirect_pc_i;

    // Flush wins over stall; the skid buffer only ever fills while stalled.
    if (flush_i) begin
      id_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (stall_i) begin
      if (w_rsp_live) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = req_pc_q;
        skid_inst_d  = imem_rdata_i;
      end
    end else if (skid_valid_q) begin
      id_valid_d   = 1'b1;
      id_pc_d      = skid_pc_q;
      id_inst_d    = skid_inst_q;
      skid_valid_d = 1'b0;
    end else if (w_rsp_live) begin
      id_valid_d = 1'b1;
      id_pc_d    = req_pc_q;
      id_inst_d  = imem_rdata_i;
    end else begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      req_pc_q     <= '0;
      drop_q       <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_inst_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      drop_q       <= drop_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      id_valid_q   <= id_valid_d;
      id_pc_q      <= id_pc_d;
      id_inst_q    <= id_inst_d;
    end
  end

  assign imem_req_o  = (state_q == S_REQ);
  assign imem_addr_o = pc_q;
  assign id_valid_o  = id_valid_q;
  assign id_pc_o     = id_pc_q;
  assign id_inst_o   = id_inst_q;

`ifdef YSYX_22040759_IFU_PERF_EN
  logic [63:0] stall_cnt_q, drop_cnt_q;
  logic [1:0]  w_drop_inc;
  logic [64:0] w_stall_sum, w_drop_sum;

  // A discarded response and a flushed ID entry can coincide, so drops may add 2.
  assign w_drop_inc  = {1'b0, w_rsp && (drop_q || flush_i)} + {1'b0, flush_i && id_valid_q};
  assign w_stall_sum = {1'b0, stall_cnt_q} + {64'd0, stall_i && !flush_i};
  assign w_drop_sum  = {1'b0, drop_cnt_q} + {63'd0, w_drop_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= w_stall_sum[64] ? '1 : w_stall_sum[63:0];
      drop_cnt_q  <= w_drop_sum[64]  ? '1 : w_drop_sum[63:0];
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_drop_cnt_o  = drop_cnt_q;
`endif

endmodule

`default_nettype wire
